// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing the single Dcache request port between two
// requesters, with one transaction in flight and a per-transaction watchdog.
module dcache_port_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  input  logic [3:0]        m0_sel_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [31:0]       m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  input  logic [3:0]        m1_sel_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [31:0]       m1_rdata_o,
  input  logic [31:0]       dcache_data_i,
  input  logic              dcache_ready_i,
  output logic [ADDR_W-1:0] dcache_raddr_o,
  output logic [ADDR_W-1:0] dcache_waddr_o,
  output logic [31:0]       dcache_wdata_o,
  output logic              dcache_rreq_o,
  output logic              dcache_wreq_o,
  output logic [3:0]        dcache_sel_o,
  output logic              busy_o,
  output logic              gnt_id_o
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              last_grant;
  logic              cur_we;

  logic              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [31:0]       win_wdata;
  logic [3:0]        win_sel;
  logic              done;
  logic [31:0]       done_rdata;
  logic              done_err;

  // Winner selection: a lone requester wins, a tie goes to the port not served last
  always_comb begin
    win       = m1_req_i;
    if (m0_req_i && m1_req_i) win = ~last_grant;
    win_we    = win ? m1_we_i    : m0_we_i;
    win_addr  = win ? m1_addr_i  : m0_addr_i;
    win_wdata = win ? m1_wdata_i : m0_wdata_i;
    win_sel   = win ? m1_sel_i   : m0_sel_i;
  end

  // Completion: Dcache ready beats the watchdog when both happen in one cycle
  always_comb begin
    done       = dcache_ready_i || (cnt == CNT_LAST);
    done_err   = ~dcache_ready_i;
    done_rdata = '0;
    if (dcache_ready_i && !cur_we) done_rdata = dcache_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      last_grant     <= 1'b1;
      cur_we         <= 1'b0;
      m0_ack_o       <= 1'b0;
      m0_err_o       <= 1'b0;
      m0_rdata_o     <= '0;
      m1_ack_o       <= 1'b0;
      m1_err_o       <= 1'b0;
      m1_rdata_o     <= '0;
      dcache_raddr_o <= '0;
      dcache_waddr_o <= '0;
      dcache_wdata_o <= '0;
      dcache_rreq_o  <= 1'b0;
      dcache_wreq_o  <= 1'b0;
      dcache_sel_o   <= '0;
      busy_o         <= 1'b0;
      gnt_id_o       <= 1'b0;
    end else begin
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            state          <= BUSY;
            busy_o         <= 1'b1;
            cnt            <= '0;
            last_grant     <= win;
            gnt_id_o       <= win;
            cur_we         <= win_we;
            dcache_raddr_o <= win_addr;
            dcache_waddr_o <= win_addr;
            dcache_wdata_o <= win_we ? win_wdata : 32'h0;
            dcache_sel_o   <= win_sel;
            dcache_rreq_o  <= ~win_we;
            dcache_wreq_o  <= win_we;
          end
        end
        BUSY: begin
          if (done) begin
            state         <= RESP;
            dcache_rreq_o <= 1'b0;
            dcache_wreq_o <= 1'b0;
            if (gnt_id_o) begin
              m1_ack_o   <= 1'b1;
              m1_err_o   <= done_err;
              m1_rdata_o <= done_rdata;
            end else begin
              m0_ack_o   <= 1'b1;
              m0_err_o   <= done_err;
              m0_rdata_o <= done_rdata;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: vector table of single transactions
// plus hand sequences for round-robin, write/read pairs and async reset.
module tb_dcache_port_arbiter;

  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned ADDR_W  = 32;
  localparam int          NEVER   = -1;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
  logic [31:0]       m0_wdata_i, m1_wdata_i;
  logic [3:0]        m0_sel_i, m1_sel_i;
  logic              m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0]       m0_rdata_o, m1_rdata_o;
  logic [31:0]       dcache_data_i;
  logic              dcache_ready_i;
  logic [ADDR_W-1:0] dcache_raddr_o, dcache_waddr_o;
  logic [31:0]       dcache_wdata_o;
  logic              dcache_rreq_o, dcache_wreq_o;
  logic [3:0]        dcache_sel_o;
  logic              busy_o, gnt_id_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] dmem [16];

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          ready_at;
    logic [31:0] dc_data;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  dcache_port_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_sel_i(m0_sel_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_sel_i(m1_sel_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
    .dcache_data_i(dcache_data_i), .dcache_ready_i(dcache_ready_i),
    .dcache_raddr_o(dcache_raddr_o), .dcache_waddr_o(dcache_waddr_o),
    .dcache_wdata_o(dcache_wdata_o), .dcache_rreq_o(dcache_rreq_o),
    .dcache_wreq_o(dcache_wreq_o), .dcache_sel_o(dcache_sel_o),
    .busy_o(busy_o), .gnt_id_o(gnt_id_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input bit req, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] sel);
    if (port) begin
      m1_req_i = req; m1_we_i = we; m1_addr_i = addr; m1_wdata_i = wdata; m1_sel_i = sel;
    end else begin
      m0_req_i = req; m0_we_i = we; m0_addr_i = addr; m0_wdata_i = wdata; m0_sel_i = sel;
    end
  endtask

  // One transaction from an idle arbiter; bench acts as the Dcache
  task automatic run_txn(input vec_t v, input bit from_mem);
    int cyc;
    int req_cycles;
    bit seen;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata, v.sel);
    dcache_ready_i = 1'b0;
    step;
    check("grant_id", 32'(gnt_id_o), 32'(v.port));
    check("grant_busy", 32'(busy_o), 32'd1);
    check("grant_rreq", 32'(dcache_rreq_o), 32'(!v.we));
    check("grant_wreq", 32'(dcache_wreq_o), 32'(v.we));
    check("grant_raddr", dcache_raddr_o, v.addr);
    check("grant_waddr", dcache_waddr_o, v.addr);
    check("grant_wdata", dcache_wdata_o, v.we ? v.wdata : 32'h0);
    check("grant_sel", 32'(dcache_sel_o), 32'(v.sel));
    req_cycles = (dcache_rreq_o || dcache_wreq_o) ? 1 : 0;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 300) begin
      dcache_ready_i = (cyc == v.ready_at);
      dcache_data_i  = from_mem ? dmem[dcache_raddr_o[7:4]] : v.dc_data;
      if (dcache_ready_i && dcache_wreq_o) dmem[dcache_waddr_o[7:4]] = dcache_wdata_o;
      step;
      dcache_ready_i = 1'b0;
      seen = v.port ? m1_ack_o : m0_ack_o;
      if (!seen) begin
        if (dcache_rreq_o || dcache_wreq_o) req_cycles++;
        cyc++;
      end
    end
    check("ack_seen", 32'(seen), 32'd1);
    check("ack_latency", 32'(cyc), 32'(v.exp_lat));
    check("req_cycles", 32'(req_cycles), 32'(v.exp_lat + 1));
    check("other_ack", 32'(v.port ? m0_ack_o : m1_ack_o), 32'd0);
    check("rdata", v.port ? m1_rdata_o : m0_rdata_o, v.exp_rdata);
    check("err", 32'(v.port ? m1_err_o : m0_err_o), 32'(v.exp_err));
    check("req_dropped", 32'({dcache_rreq_o, dcache_wreq_o}), 32'd0);
    drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step;
    check("ack_pulse_end", 32'({m0_ack_o, m1_ack_o}), 32'd0);
    check("idle_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    vec_t v;
    logic [31:0] d;
    vecs[0] = '{port:0, we:1, addr:32'h10, wdata:32'h0000_1234, sel:4'hF, ready_at:0,
                dc_data:32'h0, exp_rdata:32'h0, exp_err:0, exp_lat:0};
    vecs[1] = '{port:0, we:0, addr:32'h10, wdata:32'h0, sel:4'hF, ready_at:0,
                dc_data:32'h0000_1234, exp_rdata:32'h0000_1234, exp_err:0, exp_lat:0};
    vecs[2] = '{port:1, we:0, addr:32'h44, wdata:32'h0, sel:4'h3, ready_at:3,
                dc_data:32'hCAFE_F00D, exp_rdata:32'hCAFE_F00D, exp_err:0, exp_lat:3};
    vecs[3] = '{port:1, we:1, addr:32'h13, wdata:32'hDEAD_BEEF, sel:4'h0, ready_at:1,
                dc_data:32'h1111_1111, exp_rdata:32'h0, exp_err:0, exp_lat:1};
    vecs[4] = '{port:1, we:0, addr:32'h50, wdata:32'h0, sel:4'hF, ready_at:NEVER,
                dc_data:32'h2222_2222, exp_rdata:32'h0, exp_err:1, exp_lat:TIMEOUT-1};
    vecs[5] = '{port:0, we:0, addr:32'h60, wdata:32'h0, sel:4'hF, ready_at:TIMEOUT-1,
                dc_data:32'h0000_BEEF, exp_rdata:32'h0000_BEEF, exp_err:0, exp_lat:TIMEOUT-1};
    vecs[6] = '{port:1, we:0, addr:32'h70, wdata:32'h0, sel:4'hF, ready_at:TIMEOUT-2,
                dc_data:32'h0000_0077, exp_rdata:32'h0000_0077, exp_err:0, exp_lat:TIMEOUT-2};
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;

    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
    dcache_ready_i = 1'b0;
    dcache_data_i  = 32'h0;
    step;
    step;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_gnt", 32'(gnt_id_o), 32'd0);
    check("rst_reqs", 32'({dcache_rreq_o, dcache_wreq_o}), 32'd0);
    check("rst_acks", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'd0);
    check("rst_raddr", dcache_raddr_o, 32'h0);
    check("rst_m0_rdata", m0_rdata_o, 32'h0);
    rst = 1'b0;
    step;

    // Both ports hold read requests from reset: grants must alternate from m0
    drive(0, 1, 0, 32'h20, 32'h0, 4'hF);
    drive(1, 1, 0, 32'h30, 32'h0, 4'hF);
    dcache_ready_i = 1'b1;
    dcache_data_i  = 32'h5A5A_0000;
    for (int i = 0; i < 4; i++) begin
      int w;
      w = 0;
      while (!busy_o && w < 10) begin
        step;
        w++;
      end
      check("rr_busy", 32'(busy_o), 32'd1);
      check("rr_gnt", 32'(gnt_id_o), 32'(i % 2));
      check("rr_raddr", dcache_raddr_o, (i % 2 == 1) ? 32'h30 : 32'h20);
      step;
      check("rr_ack_winner", 32'((i % 2 == 1) ? m1_ack_o : m0_ack_o), 32'd1);
      check("rr_ack_loser", 32'((i % 2 == 1) ? m0_ack_o : m1_ack_o), 32'd0);
      step;
    end
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
    dcache_ready_i = 1'b0;
    check("rr_m0_rdata", m0_rdata_o, 32'h5A5A_0000);
    step;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], 1'b0);

    // Write/read pairs through the bench's Dcache memory model
    for (int i = 0; i < 16; i++) begin
      d = 32'($urandom_range(0, 65535));
      v = '{port:0, we:1, addr:32'(i * 16), wdata:d, sel:4'hF, ready_at:0,
            dc_data:32'h0, exp_rdata:32'h0, exp_err:0, exp_lat:0};
      run_txn(v, 1'b1);
      v = '{port:0, we:0, addr:32'(i * 16), wdata:32'h0, sel:4'hF, ready_at:0,
            dc_data:32'h0, exp_rdata:d, exp_err:0, exp_lat:0};
      run_txn(v, 1'b1);
    end

    // Asynchronous reset in the middle of a BUSY transaction
    drive(0, 1, 0, 32'h80, 32'h0, 4'hF);
    dcache_ready_i = 1'b0;
    step;
    step;
    step;
    check("pre_rst_rreq", 32'(dcache_rreq_o), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_rreq", 32'({dcache_rreq_o, dcache_wreq_o}), 32'd0);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    check("async_rst_ack", 32'({m0_ack_o, m1_ack_o}), 32'd0);
    drive(1, 1, 0, 32'h90, 32'h0, 4'hF);
    step;
    check("rst_hold_ack", 32'({m0_ack_o, m1_ack_o}), 32'd0);
    check("rst_hold_busy", 32'(busy_o), 32'd0);
    #2;
    rst = 1'b0;
    step;
    check("post_rst_gnt", 32'(gnt_id_o), 32'd0);
    check("post_rst_raddr", dcache_raddr_o, 32'h80);
    check("post_rst_busy", 32'(busy_o), 32'd1);
    dcache_ready_i = 1'b1;
    dcache_data_i  = 32'h0000_ABCD;
    step;
    dcache_ready_i = 1'b0;
    check("post_rst_m0_ack", 32'(m0_ack_o), 32'd1);
    check("post_rst_m1_ack", 32'(m1_ack_o), 32'd0);
    check("post_rst_rdata", m0_rdata_o, 32'h0000_ABCD);
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
    step;
    step;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
